// File: rtl/i2c_slave_buffer_loader_if.sv
// Bus between the button/switch front end (master) and the buffer loader (slave):
// debounced request levels and switch nibble in, buffer write port and status out.
interface i2c_slave_buffer_loader_if #(
  parameter int unsigned NIB_W  = 4,
  parameter int unsigned ADDR_W = 5
);
  logic                 EA;
  logic                 EDM;
  logic                 EDL;
  logic                 CLR;
  logic [NIB_W-1:0]     data;
  logic [ADDR_W-1:0]    WADD;
  logic [2*NIB_W-1:0]   DIN;
  logic                 W;
  logic                 BUSY;
  logic                 FULL;

  modport master (
    output EA, EDM, EDL, CLR, data,
    input  WADD, DIN, W, BUSY, FULL
  );

  modport slave (
    input  EA, EDM, EDL, CLR, data,
    output WADD, DIN, W, BUSY, FULL
  );
endinterface

// File: rtl/i2c_slave_buffer_loader.sv
// Assembles MSB/LSB nibble entries into words and writes them sequentially into the
// I2C slave transmit buffer; also supports address homing and a full-buffer fill.
module i2c_slave_buffer_loader #(
  parameter int unsigned NIB_W  = 4,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32,
  parameter bit          WRAP   = 1'b1,
  parameter int unsigned FILL   = 32'h20
) (
  input logic                      clk,
  input logic                      reset,
  i2c_slave_buffer_loader_if.slave bus_io
);

  localparam int unsigned       WordW    = 2 * NIB_W;
  localparam logic [WordW-1:0]  FillWord = WordW'(FILL);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {StIdle, StWrite, StClear} state_e;

  state_e            state_q, state_d;
  // Request bit order: {CLR, EA, EDL, EDM}
  logic [3:0]        smp_q, smp_d, prev_q, prev_d, ev;
  logic              ev_clr, ev_ea, ev_edl, ev_edm;
  logic [NIB_W-1:0]  msb_q, msb_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] wadd_q, wadd_d;
  logic [WordW-1:0]  din_q, din_d;
  logic              w_q, w_d;
  logic              busy_q, busy_d;
  logic              full_q, full_d;

  assign ev     = smp_q & ~prev_q;
  assign ev_clr = ev[3];
  assign ev_ea  = ev[2];
  assign ev_edl = ev[1];
  assign ev_edm = ev[0];

  always_comb begin
    smp_d   = {bus_io.CLR, bus_io.EA, bus_io.EDL, bus_io.EDM};
    prev_d  = smp_q;
    state_d = state_q;
    msb_d   = msb_q;
    ptr_d   = ptr_q;
    wadd_d  = wadd_q;
    din_d   = din_q;
    w_d     = 1'b0;
    busy_d  = 1'b0;
    full_d  = full_q;

    unique case (state_q)
      StIdle: begin
        if (ev_clr) begin
          state_d = StClear;
          ptr_d   = '0;
          wadd_d  = '0;
          din_d   = FillWord;
          w_d     = 1'b1;
          busy_d  = 1'b1;
        end else if (ev_ea) begin
          ptr_d  = '0;
          full_d = 1'b0;
        end else if (ev_edl) begin
          // A saturated buffer swallows further writes until homed or cleared.
          if (!full_q) begin
            state_d = StWrite;
            wadd_d  = ptr_q;
            din_d   = {msb_q, bus_io.data};
            w_d     = 1'b1;
          end
        end else if (ev_edm) begin
          msb_d = bus_io.data;
        end
      end

      StWrite: begin
        state_d = StIdle;
        if (ptr_q != LastAddr) begin
          ptr_d = ptr_q + 1'b1;
        end else if (WRAP) begin
          ptr_d = '0;
        end else begin
          full_d = 1'b1;
        end
      end

      StClear: begin
        if (ptr_q == LastAddr) begin
          state_d = StIdle;
          ptr_d   = '0;
          wadd_d  = '0;
          full_d  = 1'b0;
        end else begin
          ptr_d  = ptr_q + 1'b1;
          wadd_d = ptr_q + 1'b1;
          w_d    = 1'b1;
          busy_d = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  // Edge regs reset high so a level held through reset produces no event.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      smp_q   <= '1;
      prev_q  <= '1;
      msb_q   <= '0;
      ptr_q   <= '0;
      wadd_q  <= '0;
      din_q   <= '0;
      w_q     <= 1'b0;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      smp_q   <= smp_d;
      prev_q  <= prev_d;
      msb_q   <= msb_d;
      ptr_q   <= ptr_d;
      wadd_q  <= wadd_d;
      din_q   <= din_d;
      w_q     <= w_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
    end
  end

  assign bus_io.WADD = wadd_q;
  assign bus_io.DIN  = din_q;
  assign bus_io.W    = w_q;
  assign bus_io.BUSY = busy_q;
  assign bus_io.FULL = full_q;

endmodule

// File: tb/tb_i2c_slave_buffer_loader.sv
// Bench for i2c_slave_buffer_loader: one wrapping and one saturating instance driven
// with identical requests, checked against a transaction-level model and a vector table.
module tb_i2c_slave_buffer_loader;

  localparam int unsigned NW    = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DP    = 32;
  localparam logic [7:0]  FILLV = 8'h20;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  i2c_slave_buffer_loader_if #(.NIB_W(NW), .ADDR_W(AW)) bus0 ();
  i2c_slave_buffer_loader_if #(.NIB_W(NW), .ADDR_W(AW)) bus1 ();

  i2c_slave_buffer_loader #(
    .NIB_W(NW), .ADDR_W(AW), .DEPTH(DP), .WRAP(1'b1), .FILL(32'h20)
  ) dut0 (
    .clk(clk), .reset(rst_n), .bus_io(bus0.slave)
  );

  i2c_slave_buffer_loader #(
    .NIB_W(NW), .ADDR_W(AW), .DEPTH(DP), .WRAP(1'b0), .FILL(32'h20)
  ) dut1 (
    .clk(clk), .reset(rst_n), .bus_io(bus1.slave)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  typedef struct {
    bit         ea, edm, edl, clr;
    logic [3:0] d;
    int         nw;
    int         wadd;
    int         din;
  } vec_t;

  int  nvec = 0;
  int  nerr = 0;
  wr_t obs0[$], obs1[$];
  int  busy0, busy1;

  // Reference model state
  logic [NW-1:0] m_msb;
  int            m_ptr [2];
  bit            m_full [2];
  wr_t           m_exp0[$], m_exp1[$];

  always @(negedge clk) begin
    if (bus0.W) obs0.push_back({bus0.WADD, bus0.DIN});
    if (bus1.W) obs1.push_back({bus1.WADD, bus1.DIN});
    busy0 = busy0 + int'(bus0.BUSY);
    busy1 = busy1 + int'(bus1.BUSY);
  end

  task automatic chk(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic set_in(input bit ea, edm, edl, clr, input logic [NW-1:0] d);
    bus0.EA = ea; bus0.EDM = edm; bus0.EDL = edl; bus0.CLR = clr; bus0.data = d;
    bus1.EA = ea; bus1.EDM = edm; bus1.EDL = edl; bus1.CLR = clr; bus1.data = d;
  endtask

  task automatic model_reset();
    m_msb = '0;
    for (int k = 0; k < 2; k++) begin
      m_ptr[k]  = 0;
      m_full[k] = 1'b0;
    end
  endtask

  function automatic void exp_push(input int k, input wr_t w);
    if (k == 0) m_exp0.push_back(w);
    else m_exp1.push_back(w);
  endfunction

  // Instance 0 wraps, instance 1 saturates.
  task automatic model(input bit ea, edm, edl, clr, input logic [NW-1:0] d);
    m_exp0.delete();
    m_exp1.delete();
    for (int k = 0; k < 2; k++) begin
      if (clr) begin
        for (int i = 0; i < int'(DP); i++) exp_push(k, {AW'(i), FILLV});
        m_ptr[k]  = 0;
        m_full[k] = 1'b0;
      end else if (ea) begin
        m_ptr[k]  = 0;
        m_full[k] = 1'b0;
      end else if (edl && !m_full[k]) begin
        exp_push(k, {AW'(m_ptr[k]), m_msb, d});
        if (m_ptr[k] < int'(DP) - 1) m_ptr[k]++;
        else if (k == 0) m_ptr[k] = 0;
        else m_full[k] = 1'b1;
      end
    end
    if (!clr && !ea && !edl && edm) m_msb = d;
  endtask

  task automatic cmp_q(input string tag, input int k);
    wr_t o[$];
    wr_t e[$];
    if (k == 0) begin o = obs0; e = m_exp0; end
    else begin o = obs1; e = m_exp1; end
    chk({tag, "_nwr"}, o.size(), e.size());
    for (int i = 0; i < o.size() && i < e.size(); i++) begin
      chk({tag, "_wadd"}, int'(o[i].a), int'(e[i].a));
      chk({tag, "_din"}, int'(o[i].d), int'(e[i].d));
    end
  endtask

  // One request pulse, then enough idle cycles for the resulting write or fill.
  task automatic txn(input bit ea, edm, edl, clr, input logic [NW-1:0] d);
    obs0.delete();
    obs1.delete();
    @(posedge clk); #1;
    set_in(ea, edm, edl, clr, d);
    @(posedge clk); #1;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, d);
    repeat (clr ? DP + 4 : 4) @(posedge clk);
    #1;
    model(ea, edm, edl, clr, d);
    cmp_q("dut0", 0);
    cmp_q("dut1", 1);
    chk("full0", int'(bus0.FULL), int'(m_full[0]));
    chk("full1", int'(bus1.FULL), int'(m_full[1]));
    chk("busy0_idle", int'(bus0.BUSY), 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 1, 0, 0, 4'hA, 0, 0, 0};
    tbl[1] = '{0, 0, 1, 0, 4'h5, 1, 0, 'hA5};
    tbl[2] = '{0, 0, 1, 0, 4'h5, 1, 1, 'hA5};
    tbl[3] = '{0, 1, 0, 0, 4'h7, 0, 0, 0};
    tbl[4] = '{0, 1, 1, 0, 4'h3, 1, 2, 'h73};
    tbl[5] = '{0, 0, 1, 0, 4'h1, 1, 3, 'h71};
    tbl[6] = '{1, 0, 1, 0, 4'h9, 0, 0, 0};
    tbl[7] = '{0, 0, 1, 0, 4'h0, 1, 0, 'h70};

    busy0 = 0;
    busy1 = 0;
    rst_n = 1'b1;
    set_in(1'b0, 1'b0, 1'b1, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_w", int'(bus0.W), 0);
    chk("rst_busy", int'(bus0.BUSY), 0);
    chk("rst_full", int'(bus1.FULL), 0);
    chk("rst_wadd", int'(bus0.WADD), 0);
    chk("rst_din", int'(bus0.DIN), 0);

    // EDL held high across reset release must not write.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    obs0.delete();
    obs1.delete();
    repeat (4) @(posedge clk);
    #1;
    chk("held_edl_no_w", obs0.size(), 0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, '0);
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].ea, tbl[i].edm, tbl[i].edl, tbl[i].clr, tbl[i].d);
      chk($sformatf("tbl%0d_nw", i), obs0.size(), tbl[i].nw);
      if (tbl[i].nw > 0 && obs0.size() > 0) begin
        chk($sformatf("tbl%0d_wadd", i), int'(obs0[0].a), tbl[i].wadd);
        chk($sformatf("tbl%0d_din", i), int'(obs0[0].d), tbl[i].din);
      end
    end

    // Wrap vs saturate over 33 writes.
    do_reset();
    for (int i = 0; i < 33; i++) begin
      txn(1'b0, 1'b0, 1'b1, 1'b0, 4'($urandom));
      if (i == 31) begin
        chk("full1_after32", int'(bus1.FULL), 1);
        chk("full0_after32", int'(bus0.FULL), 0);
      end
    end
    chk("wrap_wadd", obs0.size() > 0 ? int'(obs0[0].a) : -1, 0);
    chk("sat_no_w", obs1.size(), 0);
    txn(1'b1, 1'b0, 1'b0, 1'b0, 4'h0);
    chk("full1_after_ea", int'(bus1.FULL), 0);
    txn(1'b0, 1'b0, 1'b1, 1'b0, 4'h4);
    chk("sat_home_wadd", obs1.size() > 0 ? int'(obs1[0].a) : -1, 0);

    // Clear with an EDL request landing mid-fill.
    obs0.delete();
    obs1.delete();
    busy0 = 0;
    busy1 = 0;
    @(posedge clk); #1 set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'h6);
    @(posedge clk); #1 set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'h6);
    repeat (4) @(posedge clk);
    #1 set_in(1'b0, 1'b0, 1'b1, 1'b0, 4'h6);
    @(posedge clk); #1 set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'h6);
    repeat (DP + 4) @(posedge clk);
    #1;
    model(1'b0, 1'b0, 1'b0, 1'b1, 4'h6);
    cmp_q("clr0", 0);
    cmp_q("clr1", 1);
    chk("clr_busy0_cycles", busy0, DP);
    chk("clr_busy1_cycles", busy1, DP);

    // Reset in the middle of a clear.
    @(posedge clk); #1 set_in(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    @(posedge clk); #1 set_in(1'b0, 1'b0, 1'b0, 1'b0, 4'h0);
    repeat (11) @(posedge clk);
    #1;
    chk("clr10_wadd", int'(bus0.WADD), 10);
    chk("clr10_busy", int'(bus0.BUSY), 1);
    rst_n = 1'b0;
    #1;
    chk("midclr_rst_w", int'(bus0.W), 0);
    chk("midclr_rst_busy", int'(bus0.BUSY), 0);
    chk("midclr_rst_wadd", int'(bus0.WADD), 0);
    chk("midclr_rst_w1", int'(bus1.W), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    model_reset();
    txn(1'b0, 1'b0, 1'b1, 1'b0, 4'hC);
    chk("post_rst_wadd", obs0.size() > 0 ? int'(obs0[0].a) : -1, 0);

    // Randomized request mixes.
    for (int n = 0; n < 150; n++) begin
      bit ea, edm, edl, clr;
      clr = ($urandom_range(0, 99) < 3);
      ea  = ($urandom_range(0, 99) < 15);
      edm = ($urandom_range(0, 99) < 40);
      edl = ($urandom_range(0, 99) < 50);
      txn(ea, edm, edl, clr, 4'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/i2c_slave_buffer_loader.md
# i2c_slave_buffer_loader

Parametrised loader that assembles button/switch nibble entries into words and writes them sequentially into the I2C slave's transmit buffer (LCD character RAM). It sits between the debounced button/switch front end and the dual-port buffer that the I2C slave reads. It adds address homing, buffer clear/fill, selectable wrap or saturate addressing, and a full flag.

## Interface
Parameters:
- NIB_W, 4, width of `data` nibble; word width is 2*NIB_W
- ADDR_W, 5, width of `WADD`
- DEPTH, 32, number of buffer entries; legal range 2..2**ADDR_W
- WRAP, 1, 1 = pointer wraps DEPTH-1 -> 0; 0 = pointer saturates and asserts FULL
- FILL, 8'h20, word written to every entry during clear; truncated or zero-extended to 2*NIB_W

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- EA  in  1  address-home request (level from debouncer)
- EDM  in  1  load-MSB-nibble request (level)
- EDL  in  1  load-LSB-nibble-and-write request (level)
- CLR  in  1  clear/fill request (level)
- data  in  NIB_W  nibble from switches
- WADD  out  ADDR_W  buffer write address
- DIN  out  2*NIB_W  buffer write data
- W  out  1  buffer write strobe, one cycle per write
- BUSY  out  1  high while a clear/fill is in progress
- FULL  out  1  WRAP=0 only: buffer written through DEPTH-1; always 0 when WRAP=1

## Operation
- Edge detect: each of EA, EDM, EDL, CLR passes through a sample reg and a previous reg. An event is sample=1 and previous=1'b0. Both regs reset to 1, so a level held high through reset generates no event.
- One event is accepted per cycle, with priority CLR > EA > EDL > EDM. Lower-priority coincident events are dropped.
- In CLEAR state, all events are ignored and dropped, not queued.
- Internal regs: `msb_hold` (NIB_W), pointer (ADDR_W).
- States:
  - IDLE:
    - CLR -> CLEAR with pointer=0.
    - EA -> pointer=0, FULL=0.
    - EDM -> msb_hold=data.
    - EDL -> WRITE. Latch DIN={msb_hold, data} and WADD=pointer. If FULL=1, EDL is dropped and the state stays IDLE.
  - WRITE (1 cycle): W=1. On exit, the pointer advances:
    - pointer<DEPTH-1: pointer+1.
    - pointer==DEPTH-1 and WRAP=1: pointer=0.
    - pointer==DEPTH-1 and WRAP=0: pointer holds and FULL=1.
    - Return to IDLE.
  - CLEAR: BUSY=1 and W=1 every cycle, with DIN=FILL and WADD=pointer. Pointer increments each cycle. After the write to DEPTH-1, pointer=0, FULL=0, and the state returns to IDLE.
- `msb_hold` is not cleared by a write, so repeated EDL events reuse the last MSB. A first EDL after reset uses MSB 0.
- WADD only changes at write/clear entry or during clear. In IDLE, WADD holds the last written address.

## Timing
- Reset (asynchronous, reset=0): WADD=0, DIN=0, W=0, BUSY=0, FULL=0, msb_hold=0, pointer=0, state IDLE, edge regs=1. Outputs take these values immediately, without waiting for a clock.
- Event latency: input first sampled high at edge N, event decoded in cycle N..N+1, action registered at edge N+1.
- EDL write: W=1 during cycle N+1..N+2, with WADD and DIN stable for the whole W cycle. Pointer advances at edge N+2.
- Minimum spacing: back-to-back EDL events 2 cycles apart produce W pulses 2 cycles apart. W is never high in two consecutive cycles outside CLEAR.
- CLEAR: BUSY and W rise at edge N+1 and stay high exactly DEPTH cycles. WADD steps 0..DEPTH-1. BUSY falls at the same edge where WADD returns to 0.
- FULL rises at the edge ending the write to DEPTH-1 and falls at the edge following an EA event or at the end of CLEAR.
- Reset asserted mid-CLEAR or mid-WRITE: immediate abort to reset values. The buffer may be partially written; this is acceptable.

## Test plan
- Reset release with EDL held high -> no W. Then EDM with data=4'hA, then EDL with data=4'h5 -> single W pulse, WADD=0, DIN=8'hA5; next WADD=1.
- WRAP=1, 33 EDL events -> writes to WADD 0..31 then 0. FULL stays 0.
- WRAP=0, 32 EDL events -> FULL=1 after the write to 31. A 33rd EDL produces no W. EA -> FULL=0; the next EDL writes to WADD=0.
- CLR pulse -> BUSY=1 and W=1 for exactly 32 cycles, DIN=8'h20, WADD 0..31. An EDL during clear produces no extra write.
- Same-cycle EDM+EDL with data=4'h3 after a prior MSB=4'h7 -> DIN=8'h73 and msb_hold stays 7. Same-cycle EA+EDL -> pointer=0 and no W.
- reset asserted at clear cycle 10 -> W, BUSY, WADD=0 immediately. After release, the next EDL writes to WADD=0.
